// File: rtl/sdram_req_arbiter.sv
// sdram_req_arbiter
// Merges PRG-ROM fetches (port A) and CHR-window refills (port B) into a
// single request stream for the single-port SDRAM controller. A normally
// wins. B is forced through after STARVE_LIMIT consecutive A grants made
// while B was waiting. The transaction address and the requester are latched,
// and the returned byte is routed back to the winner with a one-cycle ready
// pulse. If the controller never answers, the transaction is aborted after
// TIMEOUT cycles with 0xFF so that no requester can hang.

module sdram_req_arbiter #(
  parameter int ADDR_W       = 21,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk_mem,
  input  logic              rst,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  output logic              a_ack,
  output logic              a_ready,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  output logic              b_ack,
  output logic              b_ready,
  output logic [7:0]        rd_data,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_address,
  input  logic              mem_ready,
  input  logic [7:0]        from_mem,
  output logic              busy,
  output logic              err_timeout,
  output logic              err_spurious
);

  // Starve counter must be able to hold STARVE_LIMIT itself.
  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  // The wait counter runs 0..TIMEOUT-1. The last value marks the final WAIT cycle.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  state_e            state_q;
  logic              grant_b_q;      // 1: current transaction belongs to B
  logic [SW-1:0]     starve_q;
  logic [TW-1:0]     tmo_q;

  logic              a_ack_q;
  logic              a_ready_q;
  logic              b_ack_q;
  logic              b_ready_q;
  logic [7:0]        rd_data_q;
  logic              mem_req_q;
  logic [ADDR_W-1:0] mem_address_q;
  logic              busy_q;
  logic              err_timeout_q;
  logic              err_spurious_q;

  logic              b_starved_d;
  logic              grant_any_d;
  logic              grant_b_d;
  logic [SW-1:0]     starve_d;

  // Pick the IDLE-state winner and compute the next starve count.
  always_comb begin
    b_starved_d = b_req && (starve_q == SW'(STARVE_LIMIT));
    grant_any_d = a_req || b_req;
    grant_b_d   = b_req && (!a_req || b_starved_d);
    starve_d    = starve_q;
    if (!b_req || grant_b_d) begin
      // B is either not waiting or is being served right now.
      starve_d = '0;
    end else if (starve_q != SW'(STARVE_LIMIT)) begin
      // A wins over a waiting B: one more step toward forcing B.
      starve_d = starve_q + SW'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // Arbiter FSM with all outputs registered. Pulses default low every cycle.
  always_ff @(posedge clk_mem) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      grant_b_q      <= 1'b0;
      starve_q       <= '0;
      tmo_q          <= '0;
      a_ack_q        <= 1'b0;
      a_ready_q      <= 1'b0;
      b_ack_q        <= 1'b0;
      b_ready_q      <= 1'b0;
      rd_data_q      <= 8'h00;
      mem_req_q      <= 1'b0;
      mem_address_q  <= '0;
      busy_q         <= 1'b0;
      err_timeout_q  <= 1'b0;
      err_spurious_q <= 1'b0;
    end else begin
      mem_req_q <= 1'b0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_ready_q <= 1'b0;
      b_ready_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Data outside WAIT has no owner: flag it and drop it.
          if (mem_ready) begin
            err_spurious_q <= 1'b1;
          end else begin
            err_spurious_q <= err_spurious_q;
          end
          starve_q <= starve_d;
          if (grant_any_d) begin
            state_q       <= ST_ISSUE;
            mem_req_q     <= 1'b1;
            mem_address_q <= grant_b_d ? b_addr : a_addr;
            a_ack_q       <= !grant_b_d;
            b_ack_q       <= grant_b_d;
            grant_b_q     <= grant_b_d;
            busy_q        <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_ISSUE: begin
          if (mem_ready) begin
            err_spurious_q <= 1'b1;
          end else begin
            err_spurious_q <= err_spurious_q;
          end
          tmo_q   <= '0;
          state_q <= ST_WAIT;
          busy_q  <= 1'b1;
        end
        ST_WAIT: begin
          if (mem_ready) begin
            // Normal completion. This also wins over a timeout in the same cycle.
            rd_data_q <= from_mem;
            a_ready_q <= !grant_b_q;
            b_ready_q <= grant_b_q;
            tmo_q     <= '0;
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
          end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            // Controller never answered: release the requester with 0xFF.
            rd_data_q     <= 8'hFF;
            a_ready_q     <= !grant_b_q;
            b_ready_q     <= grant_b_q;
            err_timeout_q <= 1'b1;
            tmo_q         <= '0;
            state_q       <= ST_IDLE;
            busy_q        <= 1'b0;
          end else begin
            tmo_q   <= tmo_q + TW'(1);
            state_q <= ST_WAIT;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          tmo_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign a_ack        = a_ack_q;
  assign a_ready      = a_ready_q;
  assign b_ack        = b_ack_q;
  assign b_ready      = b_ready_q;
  assign rd_data      = rd_data_q;
  assign mem_req      = mem_req_q;
  assign mem_address  = mem_address_q;
  assign busy         = busy_q;
  assign err_timeout  = err_timeout_q;
  assign err_spurious = err_spurious_q;

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Self-checking bench for sdram_req_arbiter. Expected grants (requester,
// address, returned byte) go into a scoreboard queue when requests are raised.
// They are popped and compared when the DUT acks and returns data.

module tb_sdram_req_arbiter;
  localparam int ADDR_W = 21;

  logic              clk_mem = 1'b0;
  logic              rst = 1'b1;
  logic              a_req = 1'b0;
  logic [ADDR_W-1:0] a_addr = '0;
  logic              b_req = 1'b0;
  logic [ADDR_W-1:0] b_addr = '0;
  logic              mem_ready = 1'b0;
  logic [7:0]        from_mem = 8'h00;
  logic              a_ack, a_ready, b_ack, b_ready;
  logic [7:0]        rd_data;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_address;
  logic              busy, err_timeout, err_spurious;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic              isb;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } exp_t;

  typedef struct {
    bit                got;
    logic [ADDR_W-1:0] addr;
    logic              aack, back, ardy, brdy;
    logic [7:0]        rd;
  } obs_t;

  exp_t sb[$];

  sdram_req_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(4), .TIMEOUT(255)) dut (
    .clk_mem(clk_mem), .rst(rst),
    .a_req(a_req), .a_addr(a_addr), .a_ack(a_ack), .a_ready(a_ready),
    .b_req(b_req), .b_addr(b_addr), .b_ack(b_ack), .b_ready(b_ready),
    .rd_data(rd_data), .mem_req(mem_req), .mem_address(mem_address),
    .mem_ready(mem_ready), .from_mem(from_mem), .busy(busy),
    .err_timeout(err_timeout), .err_spurious(err_spurious)
  );

  always #5 clk_mem = ~clk_mem;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Wait (bounded) for mem_req, release the requester unless told to hold,
  // answer after 'delay' cycles, then capture the ready cycle.
  task automatic serve(input int delay, input logic [7:0] data,
                       input bit keep_a, input bit keep_b, output obs_t o);
    o.got = 1'b0; o.addr = '0; o.aack = 1'b0; o.back = 1'b0;
    o.ardy = 1'b0; o.brdy = 1'b0; o.rd = 8'h00;
    for (int i = 0; i < 20 && !o.got; i++) begin
      @(negedge clk_mem);
      if (mem_req === 1'b1) begin
        o.got = 1'b1; o.addr = mem_address; o.aack = a_ack; o.back = b_ack;
      end
    end
    if (!o.got) return;
    if (o.aack && !keep_a) a_req = 1'b0;
    if (o.back && !keep_b) b_req = 1'b0;
    repeat (delay) @(negedge clk_mem);
    mem_ready = 1'b1;
    from_mem  = data;
    @(negedge clk_mem);
    mem_ready = 1'b0;
    o.ardy = a_ready; o.brdy = b_ready; o.rd = rd_data;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk_mem);
    @(negedge clk_mem);
    checks++;
    if ({a_ack, a_ready, b_ack, b_ready, mem_req, busy, err_timeout, err_spurious} !== 8'h00)
      begin failures++; $display("FAIL reset_flags: got %b want 00000000",
        {a_ack, a_ready, b_ack, b_ready, mem_req, busy, err_timeout, err_spurious}); end
    checks++;
    if (mem_address !== 21'h0 || rd_data !== 8'h00)
      begin failures++; $display("FAIL reset_data: addr=%h rd=%h want 0/00", mem_address, rd_data); end
    rst = 1'b0;
  endtask

  task automatic test_single_a();
    obs_t o; exp_t e;
    a_addr = 21'h00123; a_req = 1'b1;
    sb.push_back('{1'b0, 21'h00123, 8'h5A});
    serve(3, 8'h5A, 1'b0, 1'b0, o);
    e = sb.pop_front();
    checks++;
    if (!o.got || o.addr !== e.addr)
      begin failures++; $display("FAIL single_a_addr: got=%0d addr=%h want %h", o.got, o.addr, e.addr); end
    checks++;
    if ({o.aack, o.back, o.ardy, o.brdy} !== 4'b1010)
      begin failures++; $display("FAIL single_a_pulses: got %b want 1010", {o.aack, o.back, o.ardy, o.brdy}); end
    checks++;
    if (o.rd !== e.data)
      begin failures++; $display("FAIL single_a_data: got %h want %h", o.rd, e.data); end
    @(negedge clk_mem);
    checks++;
    if ({a_ready, b_ready, busy} !== 3'b000)
      begin failures++; $display("FAIL single_a_after: got %b want 000", {a_ready, b_ready, busy}); end
  endtask

  task automatic test_starvation();
    obs_t o; exp_t e;
    a_addr = 21'h00AAA; b_addr = 21'h10040;
    a_req = 1'b1; b_req = 1'b1;
    for (int i = 0; i < 4; i++) sb.push_back('{1'b0, 21'h00AAA, 8'(8'h20 + i)});
    sb.push_back('{1'b1, 21'h10040, 8'h24});
    for (int i = 0; i < 5; i++) begin
      serve(2, 8'(8'h20 + i), 1'b1, 1'b0, o);
      e = sb.pop_front();
      checks++;
      if (!o.got || o.addr !== e.addr)
        begin failures++; $display("FAIL starve_grant%0d: got=%0d addr=%h want %h", i, o.got, o.addr, e.addr); end
      checks++;
      if ({o.aack, o.back, o.ardy, o.brdy} !== (e.isb ? 4'b0101 : 4'b1010) || o.rd !== e.data)
        begin failures++; $display("FAIL starve_resp%0d: pulses=%b rd=%h want isb=%0d rd=%h",
          i, {o.aack, o.back, o.ardy, o.brdy}, o.rd, e.isb, e.data); end
    end
    // Starve count must be back at 0: with both requesting, A wins first again.
    b_req = 1'b1;
    sb.push_back('{1'b0, 21'h00AAA, 8'h30});
    sb.push_back('{1'b1, 21'h10040, 8'h31});
    for (int i = 0; i < 2; i++) begin
      serve(1, 8'(8'h30 + i), 1'b0, 1'b0, o);
      e = sb.pop_front();
      checks++;
      if (!o.got || o.addr !== e.addr || {o.aack, o.back} !== (e.isb ? 2'b01 : 2'b10))
        begin failures++; $display("FAIL starve_clear%0d: addr=%h acks=%b want %h isb=%0d",
          i, o.addr, {o.aack, o.back}, e.addr, e.isb); end
    end
  endtask

  task automatic test_b_alone();
    obs_t o; exp_t e;
    b_addr = 21'h1FFFF; b_req = 1'b1;
    sb.push_back('{1'b1, 21'h1FFFF, 8'hC3});
    serve(2, 8'hC3, 1'b0, 1'b0, o);
    e = sb.pop_front();
    checks++;
    if (!o.got || o.addr !== e.addr)
      begin failures++; $display("FAIL b_alone_addr: got=%0d addr=%h want %h", o.got, o.addr, e.addr); end
    checks++;
    if ({o.aack, o.back, o.ardy, o.brdy} !== 4'b0101 || o.rd !== e.data)
      begin failures++; $display("FAIL b_alone_resp: pulses=%b rd=%h want 0101 %h",
        {o.aack, o.back, o.ardy, o.brdy}, o.rd, e.data); end
  endtask

  task automatic test_spurious_and_race();
    obs_t o; exp_t e;
    @(negedge clk_mem);
    mem_ready = 1'b1; from_mem = 8'h77;
    @(negedge clk_mem);
    mem_ready = 1'b0;
    checks++;
    if (err_spurious !== 1'b1 || rd_data !== 8'hC3 || {a_ready, b_ready} !== 2'b00)
      begin failures++; $display("FAIL spurious: err=%b rd=%h rdy=%b want 1 c3 00",
        err_spurious, rd_data, {a_ready, b_ready}); end
    // mem_ready on the last allowed WAIT cycle: normal completion.
    a_addr = 21'h00999; a_req = 1'b1;
    sb.push_back('{1'b0, 21'h00999, 8'h3C});
    serve(255, 8'h3C, 1'b0, 1'b0, o);
    e = sb.pop_front();
    checks++;
    if (!o.got || o.addr !== e.addr || {o.aack, o.ardy} !== 2'b11 || o.rd !== e.data)
      begin failures++; $display("FAIL race_complete: addr=%h ack/rdy=%b rd=%h want %h 11 %h",
        o.addr, {o.aack, o.ardy}, o.rd, e.addr, e.data); end
    checks++;
    if (err_timeout !== 1'b0 || err_spurious !== 1'b1)
      begin failures++; $display("FAIL race_flags: tmo=%b spur=%b want 0 1", err_timeout, err_spurious); end
  endtask

  task automatic test_timeout();
    obs_t o; exp_t e;
    bit got = 1'b0;
    int waited = 0;
    a_addr = 21'h00777; a_req = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk_mem);
      if (mem_req === 1'b1 && a_ack === 1'b1) got = 1'b1;
    end
    a_req = 1'b0;
    checks++;
    if (!got) begin failures++; $display("FAIL timeout_issue: no mem_req/a_ack seen"); end
    for (int i = 1; i <= 400 && waited == 0; i++) begin
      @(negedge clk_mem);
      if (a_ready === 1'b1) waited = i;
    end
    checks++;
    if (waited != 256)
      begin failures++; $display("FAIL timeout_latency: ready after %0d cycles want 256", waited); end
    checks++;
    if (rd_data !== 8'hFF || err_timeout !== 1'b1 || b_ready !== 1'b0)
      begin failures++; $display("FAIL timeout_resp: rd=%h tmo=%b brdy=%b want ff 1 0",
        rd_data, err_timeout, b_ready); end
    a_addr = 21'h00888; a_req = 1'b1;
    sb.push_back('{1'b0, 21'h00888, 8'h11});
    serve(2, 8'h11, 1'b0, 1'b0, o);
    e = sb.pop_front();
    checks++;
    if (!o.got || o.addr !== e.addr || o.ardy !== 1'b1 || o.rd !== e.data || err_timeout !== 1'b1)
      begin failures++; $display("FAIL timeout_next: addr=%h rdy=%b rd=%h tmo=%b want %h 1 %h 1",
        o.addr, o.ardy, o.rd, err_timeout, e.addr, e.data); end
  endtask

  task automatic test_reset_in_wait();
    obs_t o; exp_t e;
    bit got = 1'b0;
    a_addr = 21'h00555; a_req = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk_mem);
      if (mem_req === 1'b1 && a_ack === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got) begin failures++; $display("FAIL rst_wait_issue: no mem_req/a_ack seen"); end
    repeat (3) @(negedge clk_mem);
    rst = 1'b1;
    @(negedge clk_mem);
    rst = 1'b0;
    checks++;
    if ({a_ack, a_ready, b_ack, b_ready, mem_req, busy, err_timeout, err_spurious} !== 8'h00
        || mem_address !== 21'h0 || rd_data !== 8'h00)
      begin failures++; $display("FAIL rst_wait_clear: flags=%b addr=%h rd=%h want 0",
        {a_ack, a_ready, b_ack, b_ready, mem_req, busy, err_timeout, err_spurious}, mem_address, rd_data); end
    // a_req is still held, so the request must be accepted again.
    sb.push_back('{1'b0, 21'h00555, 8'h42});
    serve(2, 8'h42, 1'b0, 1'b0, o);
    e = sb.pop_front();
    checks++;
    if (!o.got || o.addr !== e.addr || {o.aack, o.back, o.ardy, o.brdy} !== 4'b1010 || o.rd !== e.data)
      begin failures++; $display("FAIL rst_wait_reack: addr=%h pulses=%b rd=%h want %h 1010 %h",
        o.addr, {o.aack, o.back, o.ardy, o.brdy}, o.rd, e.addr, e.data); end
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_starvation();
    test_b_alone();
    test_spurious_and_race();
    test_timeout();
    test_reset_in_wait();
    checks++;
    if (sb.size() != 0)
      begin failures++; $display("FAIL scoreboard_empty: %0d entries left want 0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
